// File: rtl/adc_spi_rx.sv
// Periodic ADC conversion controller: pulses CNV, waits for BUSY to fall, then
// reads DATA_WIDTH bits MSB first over SPI and strobes the raw sample out.
module adc_spi_rx #(
  parameter int unsigned CONV_PERIOD  = 200,
  parameter int unsigned CNV_HIGH     = 6,
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned BUSY_TIMEOUT = 100,
  parameter int unsigned DATA_WIDTH   = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_clr_err,
  output logic                  o_adc_cnv,
  input  logic                  i_adc_busy,
  output logic                  o_adc_sck,
  input  logic                  i_adc_sdo,
  output logic [DATA_WIDTH-1:0] o_adc_data,
  output logic                  o_adc_valid,
  output logic                  o_busy_timeout,
  output logic                  o_overrun
);

  localparam int unsigned PW = $clog2(CONV_PERIOD);
  localparam int unsigned SW = $clog2((CNV_HIGH > BUSY_TIMEOUT ? CNV_HIGH : BUSY_TIMEOUT) + 1);
  localparam int unsigned DW = $clog2(CLK_DIV) + 1;
  localparam int unsigned BW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNV,
    S_WAIT_BUSY,
    S_READ,
    S_DONE
  } state_t;

  state_t                state, state_n;
  logic [1:0]            busy_sync;
  logic                  busy_s;
  logic [PW-1:0]         per_cnt;
  logic [SW-1:0]         st_cnt;
  logic [DW-1:0]         div_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  tick, div_wrap, bit_fall, last_fall, timeout_hit, sck_n;

  assign busy_s = busy_sync[1];

  always_comb begin
    tick        = (per_cnt == '0) && i_en;
    div_wrap    = (div_cnt == DW'(CLK_DIV - 1));
    bit_fall    = (state == S_READ) && div_wrap && o_adc_sck;
    last_fall   = bit_fall && (bit_cnt == BW'(DATA_WIDTH - 1));
    timeout_hit = 1'b0;
    shreg_n     = shreg;
    state_n     = state;
    case (state)
      S_IDLE:      if (tick) state_n = S_CNV;
      S_CNV:       if (st_cnt == SW'(CNV_HIGH - 1)) state_n = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        // the first two cycles still reflect pre-conversion BUSY through the synchroniser
        if (st_cnt >= SW'(2) && !busy_s) begin
          state_n = S_READ;
        end else if (st_cnt == SW'(BUSY_TIMEOUT - 1)) begin
          state_n     = S_IDLE;
          timeout_hit = i_en;
        end
      end
      S_READ:      if (last_fall) state_n = S_DONE;
      S_DONE:      state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
    if (!i_en) state_n = S_IDLE;
    if (bit_fall) shreg_n = {shreg[DATA_WIDTH-2:0], i_adc_sdo};
    sck_n = 1'b0;
    if (state == S_READ && state_n == S_READ) sck_n = div_wrap ? ~o_adc_sck : o_adc_sck;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state          <= S_IDLE;
      busy_sync      <= '0;
      per_cnt        <= '0;
      st_cnt         <= '0;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      o_adc_cnv      <= 1'b0;
      o_adc_sck      <= 1'b0;
      o_adc_data     <= '0;
      o_adc_valid    <= 1'b0;
      o_busy_timeout <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      state     <= state_n;
      busy_sync <= {busy_sync[0], i_adc_busy};
      if (!i_en || per_cnt == PW'(CONV_PERIOD - 1)) per_cnt <= '0;
      else                                          per_cnt <= per_cnt + 1'b1;
      if ((state == S_CNV || state == S_WAIT_BUSY) && state_n == state) st_cnt <= st_cnt + 1'b1;
      else                                                              st_cnt <= '0;
      if (state == S_READ && !div_wrap) div_cnt <= div_cnt + 1'b1;
      else                              div_cnt <= '0;
      if (state != S_READ) bit_cnt <= '0;
      else if (bit_fall)   bit_cnt <= bit_cnt + 1'b1;
      shreg     <= shreg_n;
      o_adc_sck <= sck_n;
      o_adc_cnv <= (state_n == S_CNV);
      o_adc_valid <= (state == S_READ) && (state_n == S_DONE);
      if (state == S_READ && state_n == S_DONE) o_adc_data <= shreg_n;
      if (timeout_hit)    o_busy_timeout <= 1'b1;
      else if (i_clr_err) o_busy_timeout <= 1'b0;
      if (tick && state != S_IDLE) o_overrun <= 1'b1;
      else if (i_clr_err)          o_overrun <= 1'b0;
    end
  end

endmodule
